// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that shares one 8N1 UART transmitter
// between a console requester (0) and a debug/trace requester (1).
module uart_tx_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 4095,
  parameter int unsigned TW           = 12
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       req0,
  input  logic [7:0] dat0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] dat1,
  input  logic       last1,
  output logic       ack1,
  output logic [1:0] owner,
  output logic       uart_wr,
  output logic [7:0] uart_dat,
  input  logic       uart_busy
);

  localparam int unsigned DW      = 8;
  localparam int unsigned OW      = 2;
  localparam bit          TO_EN   = (LOCK_TIMEOUT != 0);
  localparam logic [TW-1:0] TO_VAL  = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] CNT_MAX = {TW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_ARM,
    S_DRAIN,
    S_LOCKED
  } state_t;

  state_t        state;
  logic          lock;
  logic          rr;
  logic          win;
  logic [TW-1:0] cnt;

  // Request/last of the requester currently being served.
  logic win_req_c;
  logic win_last_c;
  assign win_req_c  = win ? req1  : req0;
  assign win_last_c = win ? last1 : last0;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state    <= S_IDLE;
      lock     <= 1'b0;
      rr       <= 1'b0;
      win      <= 1'b0;
      cnt      <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      owner    <= OW'(0);
      uart_wr  <= 1'b0;
      uart_dat <= DW'(0);
    end else begin
      uart_wr <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!uart_busy && (req0 || req1)) begin
            if (req0 && req1) begin
              // Contention: rr names the winner, then points at the loser.
              win      <= rr;
              uart_dat <= rr ? dat1 : dat0;
              rr       <= ~rr;
            end else if (req0) begin
              win      <= 1'b0;
              uart_dat <= dat0;
            end else begin
              win      <= 1'b1;
              uart_dat <= dat1;
            end
            state <= S_SEND;
          end
        end

        S_SEND: begin
          if (win_req_c) begin
            uart_wr <= 1'b1;
            ack0    <= ~win;
            ack1    <= win;
            lock    <= ~win_last_c;
            owner   <= win ? 2'b10 : 2'b01;
            state   <= S_ARM;
          end else begin
            // Request withdrawn before it was acknowledged: nothing is sent.
            state <= lock ? S_LOCKED : S_IDLE;
          end
        end

        // Transmitter raises busy one cycle after the write strobe.
        S_ARM: state <= S_DRAIN;

        S_DRAIN: begin
          if (!uart_busy) begin
            if (lock) begin
              state <= S_LOCKED;
              cnt   <= '0;
            end else begin
              state <= S_IDLE;
              owner <= OW'(0);
            end
          end
        end

        S_LOCKED: begin
          if (TO_EN && (cnt == TO_VAL)) begin
            // Timeout takes priority over a request arriving the same cycle.
            lock  <= 1'b0;
            owner <= OW'(0);
            cnt   <= '0;
            state <= S_IDLE;
          end else if (win_req_c && !uart_busy) begin
            uart_dat <= win ? dat1 : dat0;
            cnt      <= '0;
            state    <= S_SEND;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + TW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
